rgb_sinp_fifo: RTL
==================

// Module: rgb_sinp_fifo
// PURPOSE
//  Serial WS2812B receiver: samples one-wire RGB input at 96 MHz, classifies each high pulse as 0/1,
//  assembles 24-bit G-R-B pixels, writes 32-bit status+pixel words into the input-side FIFO.
//  Feeds the FIFO that the RGBW serial transmitter drains; word format identical on both ends.
// PARAMETERS
//  COUNTER_MAX        7800  counter ceiling; width = $clog2(COUNTER_MAX+1); counters saturate here
//  STREAM_RESET_CLKS  4800  low time (~50 us) that marks a stream reset
//  BIT1_MIN_HIGH_CLKS 58    high time >= this decodes as 1, else 0 (T0H~38, T1H~77 clks)
//  GLITCH_CLKS        10    high pulse < this ignored entirely (no bit, no timer restart)
//  MAX_HIGH_CLKS      144   high pulse > this is a protocol error
// PORTS
//  clk                in   1   96 MHz system clock, synchronous with FIFO w_clk
//  rst_n              in   1   asynchronous active-low reset
//  in_sig             in   1   serial WS2812B line, asynchronous to clk
//  in_wr_fifo_full    in   1   FIFO write-side full
//  out_wr_fifo_en     out  1   FIFO write enable, one-cycle pulse
//  out_wr_fifo_data   out  32  FIFO write data, valid when out_wr_fifo_en=1
//  out_overflow       out  1   sticky: a word was dropped because FIFO full
//  out_proto_err      out  1   sticky: over-long high or partial pixel discarded
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, sync flops 0, state IDLE, bit count 0, armed=0.
//  Input: 2-flop synchronizer + 3rd flop for edge detect; all decisions on synchronized level.
//  Word format: [31] valid, [30] stream_reset, [29:24] 0, [23:0] G[23:16] R[15:8] B[7:0]; first bit rx -> bit 23.
//  Data word = {1'b1,1'b0,6'b0,pixel}; reset word = 32'h4000_0000.
//  States:
//   IDLE: line low, no bits pending. Rising edge -> HIGH, hi_cnt=1.
//   HIGH: hi_cnt++ (saturating). Falling edge: hi_cnt<GLITCH_CLKS -> back to previous state
//         (IDLE or LOW, lo_cnt keeps counting); else shift in (hi_cnt>=BIT1_MIN_HIGH_CLKS), bits++, armed=1,
//         lo_cnt=0 -> LOW. hi_cnt>MAX_HIGH_CLKS -> out_proto_err=1, bits=0 -> ERR.
//   LOW:  lo_cnt++. Rising edge -> HIGH. lo_cnt==STREAM_RESET_CLKS -> emit reset word if armed;
//         bits!=0 sets out_proto_err and discards partial; armed=0, bits=0 -> IDLE.
//   ERR:  ignore pulses; line low continuously for STREAM_RESET_CLKS -> emit reset word -> IDLE
//         (any high restarts the low timer).
//  24th bit: write data word, bits=0, stay LOW (next pixel follows, WS2812 chain).
//  Latency: out_wr_fifo_en asserted exactly 3 clk after first posedge sampling 24th falling edge low.
//  Write rule: write only if in_wr_fifo_full=0 that cycle; if full, drop word, set out_overflow; no retry.
//  out_wr_fifo_data holds last written word between pulses. Reset word and data word never same cycle.
//  Sticky flags clear only on rst_n. Reset mid-word discards all partial state, no write emitted.
// STRUCTURE
//  Shared package rgb_pkg: word bit positions (valid=31, stream_reset=30, G/R/B fields),
//  WS2812B/SK6812 timing constants in 96 MHz clocks, reset-word constant.
//  Sub-module rgb_sync_edge: 2-flop synchronizer + rise/fall one-cycle pulses, async active-low reset.
// TESTING
//  1 Send pixel G=A5 R=3C B=0F (T0H 38/T1H 77, 120-clk bit period), then 4800 low
//    -> writes 32'h80A5_3C0F then 32'h4000_0000; flags 0.
//  2 Two pixels back-to-back 0xFFFFFF, 0x000000 -> writes 80FF_FFFF, 8000_0000, then 4000_0000.
//  3 10 bits then 4800 low -> single write 4000_0000, out_proto_err=1, no data word.
//  4 5-clk glitch high mid-pixel 0x123456 -> glitch ignored, writes 8012_3456.
//  5 300-clk high pulse -> out_proto_err=1, no writes; 4800 low -> 4000_0000; next pixel decodes normally.
//  6 in_wr_fifo_full=1 at 24th bit -> no wr_en, out_overflow=1; full=0, next pixel written normally.
//  7 rst_n low after 12 bits -> all outputs 0 immediately; next full pixel 0xABCDEF -> 80AB_CDEF.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared WS2812B/SK6812 word layout and timing constants (96 MHz clocks) for the
// serial RGB receive and transmit paths.
package rgb_pkg;
  localparam int COUNTER_MAX        = 7800;
  localparam int STREAM_RESET_CLKS  = 4800;
  localparam int BIT1_MIN_HIGH_CLKS = 58;
  localparam int GLITCH_CLKS        = 10;
  localparam int MAX_HIGH_CLKS      = 144;
  localparam int T0H_CLKS           = 38;
  localparam int T1H_CLKS           = 77;
  localparam int BIT_PERIOD_CLKS    = 120;

  localparam int WORD_VALID_BIT = 31;
  localparam int WORD_SRST_BIT  = 30;
  localparam int G_LSB          = 16;
  localparam int R_LSB          = 8;
  localparam int B_LSB          = 0;
  localparam int PIXEL_BITS     = 24;

  localparam logic [31:0] RESET_WORD = 32'h4000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_ERR} rx_state_e;

  function automatic logic [31:0] data_word(input logic [23:0] px);
    return {1'b1, 1'b0, 6'b0, px};
  endfunction
endpackage

// File: rtl/rgb_sync_edge.sv
// Two-flop synchronizer for the async serial line plus a third flop that yields
// single-cycle rise/fall pulses on the synchronized level.
module rgb_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/rgb_sinp_fifo.sv
// WS2812B one-wire receiver: measures high pulses, assembles G-R-B pixels and
// pushes status+pixel words (or stream-reset words) into the input FIFO.
module rgb_sinp_fifo
  import rgb_pkg::*;
#(
  parameter int COUNTER_MAX_P        = COUNTER_MAX,
  parameter int STREAM_RESET_CLKS_P  = STREAM_RESET_CLKS,
  parameter int BIT1_MIN_HIGH_CLKS_P = BIT1_MIN_HIGH_CLKS,
  parameter int GLITCH_CLKS_P        = GLITCH_CLKS,
  parameter int MAX_HIGH_CLKS_P      = MAX_HIGH_CLKS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_sig,
  input  logic        in_wr_fifo_full,
  output logic        out_wr_fifo_en,
  output logic [31:0] out_wr_fifo_data,
  output logic        out_overflow,
  output logic        out_proto_err
);
  localparam int CNT_W = $clog2(COUNTER_MAX_P + 1);
  localparam logic [CNT_W-1:0] CMAX    = CNT_W'(COUNTER_MAX_P);
  localparam logic [CNT_W-1:0] SRST_C  = CNT_W'(STREAM_RESET_CLKS_P);
  localparam logic [CNT_W-1:0] BIT1_C  = CNT_W'(BIT1_MIN_HIGH_CLKS_P);
  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_CLKS_P);
  localparam logic [CNT_W-1:0] MAXH_C  = CNT_W'(MAX_HIGH_CLKS_P);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  logic lvl, rise, fall;

  rgb_sync_edge u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (in_sig),
    .q    (lvl),
    .rise (rise),
    .fall (fall)
  );

  rx_state_e        state, state_n;
  logic [CNT_W-1:0] hi_cnt, hi_n, lo_cnt, lo_n;
  logic [4:0]       bits, bits_n;
  logic [23:0]      shreg, sh_n;
  logic             armed, armed_n, prev_low, prev_n, perr_n, new_bit;
  logic             emit, pend_vld;
  logic [31:0]      emit_word, pend_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hi_cnt        <= '0;
      lo_cnt        <= '0;
      bits          <= '0;
      shreg         <= '0;
      armed         <= 1'b0;
      prev_low      <= 1'b0;
      out_proto_err <= 1'b0;
    end else begin
      state         <= state_n;
      hi_cnt        <= hi_n;
      lo_cnt        <= lo_n;
      bits          <= bits_n;
      shreg         <= sh_n;
      armed         <= armed_n;
      prev_low      <= prev_n;
      out_proto_err <= perr_n;
    end
  end

  always_comb begin
    state_n   = state;
    hi_n      = hi_cnt;
    lo_n      = lo_cnt;
    bits_n    = bits;
    sh_n      = shreg;
    armed_n   = armed;
    prev_n    = prev_low;
    perr_n    = out_proto_err;
    new_bit   = 1'b0;
    emit      = 1'b0;
    emit_word = '0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_HIGH;
          hi_n    = CNT_W'(1);
          prev_n  = 1'b0;
        end
      end
      ST_HIGH: begin
        hi_n = sat_inc(hi_cnt);
        // low timer keeps running so a glitch does not postpone a stream reset
        lo_n = sat_inc(lo_cnt);
        if (fall) begin
          if (hi_cnt < GLITCH_C) begin
            state_n = prev_low ? ST_LOW : ST_IDLE;
          end else begin
            new_bit = (hi_cnt >= BIT1_C);
            sh_n    = {shreg[22:0], new_bit};
            armed_n = 1'b1;
            lo_n    = '0;
            state_n = ST_LOW;
            if (bits == 5'(PIXEL_BITS - 1)) begin
              emit      = 1'b1;
              emit_word = data_word(sh_n);
              bits_n    = '0;
            end else begin
              bits_n = bits + 5'd1;
            end
          end
        end else if (hi_cnt > MAXH_C) begin
          perr_n  = 1'b1;
          bits_n  = '0;
          lo_n    = '0;
          state_n = ST_ERR;
        end
      end
      ST_LOW: begin
        lo_n = sat_inc(lo_cnt);
        if (rise) begin
          state_n = ST_HIGH;
          hi_n    = CNT_W'(1);
          prev_n  = 1'b1;
        end else if (lo_cnt >= SRST_C) begin
          emit      = armed;
          emit_word = RESET_WORD;
          if (bits != '0) perr_n = 1'b1;
          armed_n   = 1'b0;
          bits_n    = '0;
          state_n   = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (lvl) begin
          lo_n = '0;
        end else if (lo_cnt >= SRST_C) begin
          emit      = 1'b1;
          emit_word = RESET_WORD;
          armed_n   = 1'b0;
          state_n   = ST_IDLE;
        end else begin
          lo_n = sat_inc(lo_cnt);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // One staging register then the FIFO write; full is checked at the write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld         <= 1'b0;
      pend_word        <= '0;
      out_wr_fifo_en   <= 1'b0;
      out_wr_fifo_data <= '0;
      out_overflow     <= 1'b0;
    end else begin
      pend_vld       <= emit;
      pend_word      <= emit_word;
      out_wr_fifo_en <= pend_vld & ~in_wr_fifo_full;
      if (pend_vld & ~in_wr_fifo_full) out_wr_fifo_data <= pend_word;
      if (pend_vld & in_wr_fifo_full)  out_overflow     <= 1'b1;
    end
  end
endmodule
